core_rst_sequencer: RTL

Reset sequencer that sits directly upstream of the core_v_verif_fpga reset input, in the core-slow clock domain. It combines MMCM lock status and the board reset switch, then produces a clean active-high core reset with deterministic hold time and synchronous deassertion. It re-asserts core reset on MMCM lock loss or a debounced switch press, and counts those re-assertions for debug and LED display.

---
 rtl/core_rst_seq_pkg.sv | 14 +
 rtl/rst_sw_debouncer.sv | 45 ++++
 rtl/core_rst_sequencer.sv | 136 +++++++++++++
 3 files changed

// File: rtl/core_rst_seq_pkg.sv
// Shared types and constants for the core reset sequencer.
// Optional lock-loss glitch filter is enabled by defining RST_SEQ_LOCK_FILTER_EN.
package core_rst_seq_pkg;

   typedef enum logic [1:0] {
      WAIT_LOCK = 2'b00,
      HOLD      = 2'b01,
      RUN       = 2'b10
   } rst_seq_state_e;

   localparam int LOCK_FILTER_LEN = 4;
   localparam int SYNC_STAGES     = 2;

endpackage

// File: rtl/rst_sw_debouncer.sv
// Board reset switch conditioner: 2-FF synchronizer followed by a stability counter
// that moves the output level only after DEBOUNCE_CYCLES consecutive differing samples.
module rst_sw_debouncer
   import core_rst_seq_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = 1024
) (
   input  logic i_clk,
   input  logic i_rst_n,
   input  logic i_sw,
   output logic o_sw_db
);

   localparam int             CW   = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
   localparam logic [CW-1:0]  LAST = CW'(DEBOUNCE_CYCLES - 1);

   logic [SYNC_STAGES-1:0] r_sync;
   logic                   r_db;
   logic [CW-1:0]          r_cnt;
   logic                   w_sw_s;

   assign w_sw_s  = r_sync[SYNC_STAGES-1];
   assign o_sw_db = r_db;

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) r_sync <= '0;
      else          r_sync <= {r_sync[SYNC_STAGES-2:0], i_sw};
   end

   // Any sample agreeing with the current level restarts the stability window.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_db  <= 1'b0;
         r_cnt <= '0;
      end else if (w_sw_s == r_db) begin
         r_cnt <= '0;
      end else if (r_cnt == LAST) begin
         r_db  <= w_sw_s;
         r_cnt <= '0;
      end else begin
         r_cnt <= r_cnt + CW'(1);
      end
   end

endmodule

// File: rtl/core_rst_sequencer.sv
// Core reset sequencer: gates core reset on MMCM lock and debounced switch, counts re-assertions.
// Define RST_SEQ_LOCK_FILTER_EN to ignore lock glitches shorter than LOCK_FILTER_LEN cycles.
module core_rst_sequencer
   import core_rst_seq_pkg::*;
#(
   parameter int HOLD_CYCLES     = 16,
   parameter int DEBOUNCE_CYCLES = 1024,
   parameter int CNT_W           = 8
) (
   input  logic             clk_core_slow_i,
   input  logic             rst_n_i,
   input  logic             mmcm_locked_i,
   input  logic             rst_sw_i,
   output logic             rst_core_o,
   output logic             core_ready_o,
   output logic [CNT_W-1:0] rst_event_cnt_o,
   output logic [1:0]       state_o
);

   localparam int                HOLD_W    = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
   localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_CYCLES - 1);

   logic [SYNC_STAGES-1:0] r_rst_sync;
   logic [SYNC_STAGES-1:0] r_lock_sync;
   logic                   w_rst_n;
   logic                   w_lock_sync;
   logic                   w_lock_lost;
   logic                   w_sw_db;

   rst_seq_state_e    r_state;
   rst_seq_state_e    w_state_nxt;
   logic [HOLD_W-1:0] r_hold_cnt;
   logic [HOLD_W-1:0] w_hold_nxt;
   logic [CNT_W-1:0]  r_evt_cnt;
   logic              w_event;
   logic              r_rst_core;

   // Internal reset asserts with rst_n_i and releases on the second clock after it.
   always_ff @(posedge clk_core_slow_i or negedge rst_n_i) begin
      if (!rst_n_i) r_rst_sync <= '0;
      else          r_rst_sync <= {r_rst_sync[SYNC_STAGES-2:0], 1'b1};
   end
   assign w_rst_n = r_rst_sync[SYNC_STAGES-1];

   always_ff @(posedge clk_core_slow_i or negedge rst_n_i) begin
      if (!rst_n_i) r_lock_sync <= '0;
      else          r_lock_sync <= {r_lock_sync[SYNC_STAGES-2:0], mmcm_locked_i};
   end
   assign w_lock_sync = r_lock_sync[SYNC_STAGES-1];

`ifdef RST_SEQ_LOCK_FILTER_EN
   localparam int            LF_W    = $clog2(LOCK_FILTER_LEN);
   localparam logic [LF_W-1:0] LF_LAST = LF_W'(LOCK_FILTER_LEN - 1);

   logic [LF_W-1:0] r_low_cnt;

   always_ff @(posedge clk_core_slow_i or negedge w_rst_n) begin
      if (!w_rst_n)                r_low_cnt <= '0;
      else if (w_lock_sync)        r_low_cnt <= '0;
      else if (r_low_cnt != LF_LAST) r_low_cnt <= r_low_cnt + LF_W'(1);
   end

   // The current low sample plus LOCK_FILTER_LEN-1 earlier ones make a real loss.
   assign w_lock_lost = !w_lock_sync && (r_low_cnt == LF_LAST);
`else
   assign w_lock_lost = !w_lock_sync;
`endif

   rst_sw_debouncer #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
   ) u_sw_db (
      .i_clk   (clk_core_slow_i),
      .i_rst_n (w_rst_n),
      .i_sw    (rst_sw_i),
      .o_sw_db (w_sw_db)
   );

   always_comb begin
      w_state_nxt = r_state;
      w_hold_nxt  = r_hold_cnt;
      w_event     = 1'b0;
      case (r_state)
         WAIT_LOCK: begin
            if (w_lock_sync) begin
               w_state_nxt = HOLD;
               w_hold_nxt  = '0;
            end
         end
         HOLD: begin
            if (w_lock_lost) begin
               w_state_nxt = WAIT_LOCK;
               w_hold_nxt  = '0;
            end else if (w_sw_db) begin
               w_hold_nxt  = '0;
            end else if (r_hold_cnt == HOLD_LAST) begin
               w_state_nxt = RUN;
               w_hold_nxt  = '0;
            end else begin
               w_hold_nxt  = r_hold_cnt + HOLD_W'(1);
            end
         end
         RUN: begin
            // Simultaneous lock loss and switch press is a single event.
            if (w_lock_lost || w_sw_db) begin
               w_state_nxt = HOLD;
               w_hold_nxt  = '0;
               w_event     = 1'b1;
            end
         end
         default: begin
            w_state_nxt = WAIT_LOCK;
            w_hold_nxt  = '0;
         end
      endcase
   end

   always_ff @(posedge clk_core_slow_i or negedge w_rst_n) begin
      if (!w_rst_n) begin
         r_state    <= WAIT_LOCK;
         r_hold_cnt <= '0;
         r_evt_cnt  <= '0;
         r_rst_core <= 1'b1;
      end else begin
         r_state    <= w_state_nxt;
         r_hold_cnt <= w_hold_nxt;
         r_rst_core <= (w_state_nxt != RUN);
         if (w_event && (r_evt_cnt != '1)) r_evt_cnt <= r_evt_cnt + CNT_W'(1);
      end
   end

   assign rst_core_o      = r_rst_core;
   assign core_ready_o    = (r_state == RUN);
   assign rst_event_cnt_o = r_evt_cnt;
   assign state_o         = r_state;

endmodule
